// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage, LSB first.
// The RxD line passes through a two-flop synchronizer and is oversampled
// OVERSAMPLE times per bit. Each bit is decided by a 3-sample majority vote
// around the bit centre. Start and stop bits are validated. Each good byte is
// presented with a one-cycle rx_valid strobe. A bad stop bit pulses
// framing_error, then the block waits for the line to return high.
module uart_receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxData,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_S0     = OW'(M - 1);
    localparam logic [OW-1:0] OS_S1     = OW'(M);
    localparam logic [OW-1:0] OS_DEC    = OW'(M + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic            rx_prev;
    logic [TW-1:0]   tick_cnt;
    logic [OW-1:0]   os_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            s0;
    logic            s1;
    logic            tick;
    logic            start_edge;
    logic            vote;
    logic            at_dec;
    logic            at_end;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= RxD;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Tick strobe, start-edge detect, and the majority vote of the two stored
    // samples with the current sample.
    always_comb begin
        tick       = (tick_cnt == TICK_LAST);
        start_edge = (state == IDLE) && rx_prev && !rx_s;
        vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        at_dec     = tick && (os_cnt == OS_DEC);
        at_end     = tick && (os_cnt == OS_LAST);
    end

    // Receive FSM with its tick/oversample counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            os_cnt        <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            s0            <= 1'b1;
            s1            <= 1'b1;
            RxData        <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;

            // Bit timing restarts from the detected start edge
            if (start_edge || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (start_edge) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end

            if (tick && (os_cnt == OS_S0)) begin
                s0 <= rx_s;
            end
            if (tick && (os_cnt == OS_S1)) begin
                s1 <= rx_s;
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_edge) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (at_dec && vote) begin
                        // Start bit did not hold low at its centre: treat as a glitch
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end

                DATA: begin
                    if (at_dec) begin
                        shreg[bit_idx] <= vote;
                    end
                    if (at_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                STOP: begin
                    // Decide at the stop-bit centre so the next start edge can
                    // follow as soon as half a bit later.
                    if (at_dec) begin
                        if (vote) begin
                            RxData   <= shreg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= BREAK_WAIT;
                        end
                    end
                end

                BREAK_WAIT: begin
                    // A held-low line must go high before a new start edge counts
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives serial 8N1 frames into uart_receiver.
// Expected bytes and framing errors are pushed into an event queue, and a
// negedge monitor matches every output pulse against that queue.
module tb_uart_receiver;

    localparam int BIT = 434;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxData;
    logic       rx_valid;
    logic       framing_error;
    logic       busy;

    uart_receiver #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RxD          (RxD),
        .RxData       (RxData),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;
    logic       busy_seen = 1'b0;

    // Match every output pulse against the next expected event
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rx_valid || framing_error) begin
            check_val("exclusive", {31'b0, rx_valid & framing_error}, 32'd0);
            if (exp_q.size() == 0) begin
                check_val("spurious_pulse", {30'b0, rx_valid, framing_error}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("event_kind", {31'b0, framing_error}, {31'b0, mon_e.is_err});
                if (rx_valid && !mon_e.is_err) begin
                    check_val("rx_data", {24'b0, RxData}, {24'b0, mon_e.data});
                    last_good = mon_e.data;
                end
                if (framing_error) begin
                    check_val("rx_hold", {24'b0, RxData}, {24'b0, last_good});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame clock by clock; the stop-bit level/length and an optional
    // inverted window (clk offsets from the start-bit edge) are selectable.
    task automatic send_frame(input logic [7:0] b, input int bit_clk, input int stop_clk,
                              input logic stop_val, input int g_start, input int g_len);
        int   total;
        int   idx;
        logic v;
        total = 9 * bit_clk + stop_clk;
        for (int c = 0; c < total; c++) begin
            idx = c / bit_clk;
            if (idx == 0)      v = 1'b0;
            else if (idx <= 8) v = b[idx-1];
            else               v = stop_val;
            if (c >= g_start && c < g_start + g_len) v = ~v;
            @(negedge clk);
            RxD = v;
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back('{1'b0, b});
    endtask

    task automatic expect_err();
        exp_q.push_back('{1'b1, 8'h00});
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic drain(input string tag);
        idle(BIT);
        check_val(tag, exp_q.size(), 32'd0);
    endtask

    logic [7:0] seq[3] = '{8'h00, 8'hFF, 8'h55};

    initial begin
        logic [7:0] rb;
        int         rbit;
        int         rstop;

        // Reset state
        repeat (4) @(negedge clk);
        check_val("rst_data",  {24'b0, RxData}, 32'd0);
        check_val("rst_valid", {31'b0, rx_valid}, 32'd0);
        check_val("rst_ferr",  {31'b0, framing_error}, 32'd0);
        check_val("rst_busy",  {31'b0, busy}, 32'd0);
        reset = 1'b1;
        idle(10);

        // Plain frame
        expect_byte(8'hA5);
        send_frame(8'hA5, BIT, BIT, 1'b1, -1, 0);
        wait_idle("t1_idle", 2 * BIT);
        drain("t1_pending");
        check_val("t1_data", {24'b0, RxData}, 32'hA5);

        // Short low glitch is rejected as a start bit
        busy_seen = 1'b0;
        repeat (135) begin
            @(negedge clk);
            RxD = 1'b0;
        end
        @(negedge clk);
        RxD = 1'b1;
        idle(BIT);
        check_val("t2_busy_seen", {31'b0, busy_seen}, 32'd1);
        check_val("t2_busy", {31'b0, busy}, 32'd0);
        check_val("t2_pending", exp_q.size(), 32'd0);
        expect_byte(8'h3C);
        send_frame(8'h3C, BIT, BIT, 1'b1, -1, 0);
        drain("t2_pending2");

        // Bad stop bit followed by a long break
        expect_err();
        send_frame(8'h3C, BIT, 20 * BIT, 1'b0, -1, 0);
        check_val("t3_break_busy", {31'b0, busy}, 32'd1);
        check_val("t3_ferr_seen", exp_q.size(), 32'd0);
        check_val("t3_hold", {24'b0, RxData}, {24'b0, last_good});
        @(negedge clk);
        RxD = 1'b1;
        idle(BIT);
        wait_idle("t3_idle", BIT);
        expect_byte(8'h81);
        send_frame(8'h81, BIT, BIT, 1'b1, -1, 0);
        drain("t3_pending");

        // Back-to-back frames with full and 0.6-bit stop spacing
        for (int i = 0; i < 3; i++) begin
            expect_byte(seq[i]);
            send_frame(seq[i], BIT, BIT, 1'b1, -1, 0);
        end
        drain("t4_full_stop");
        for (int i = 0; i < 3; i++) begin
            expect_byte(seq[i]);
            send_frame(seq[i], BIT, (BIT * 6) / 10, 1'b1, -1, 0);
        end
        drain("t4_short_stop");
        check_val("t4_last", {24'b0, RxData}, 32'h55);

        // One-tick inverted glitch at the centre sample of data bit 3
        expect_byte(8'h96);
        send_frame(8'h96, BIT, BIT, 1'b1, 1958, 27);
        drain("t5_pending");

        // Reset asserted mid-frame during data bit 4
        fork
            send_frame(8'hF5, BIT, BIT, 1'b1, -1, 0);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                check_val("t6_busy_pre", {31'b0, busy}, 32'd1);
                reset = 1'b0;
                @(negedge clk);
                check_val("t6_data",  {24'b0, RxData}, 32'd0);
                check_val("t6_valid", {31'b0, rx_valid}, 32'd0);
                check_val("t6_ferr",  {31'b0, framing_error}, 32'd0);
                check_val("t6_busy",  {31'b0, busy}, 32'd0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                last_good = 8'h00;
            end
        join
        idle(BIT);
        check_val("t6_busy_after", {31'b0, busy}, 32'd0);
        expect_byte(8'hC3);
        send_frame(8'hC3, BIT, BIT, 1'b1, -1, 0);
        drain("t6_pending");

        // Random bytes, bit-rate skew, stop spacing and occasional bad stop bits
        for (int i = 0; i < 3; i++) begin
            rb    = 8'($urandom);
            rbit  = int'($urandom_range(430, 438));
            rstop = (rbit * int'($urandom_range(75, 100))) / 100;
            if ($urandom_range(0, 3) == 0) begin
                expect_err();
                send_frame(rb, rbit, rbit, 1'b0, -1, 0);
                @(negedge clk);
                RxD = 1'b1;
            end else begin
                expect_byte(rb);
                send_frame(rb, rbit, rstop, 1'b1, -1, 0);
            end
            idle(int'($urandom_range(20, 200)));
        end
        drain("rand_pending");
        wait_idle("final_idle", BIT);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
